bsg_min_tag_sched: RTL and testbench

BSG_MIN_TAG_SCHED -- requirements
Module: bsg_min_tag_sched

---
 rtl/bsg_min_tag_sched.sv | 161 ++++++++++++++++
 tb/tb_bsg_min_tag_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_min_tag_sched.sv
// bsg_min_tag_sched: minimum-tag scheduler with one time-shared comparator.
// On any valid request the block snapshots all valids and tags, walks every
// requester with a single less-than comparator (one per cycle), then presents
// the lowest-tag requester (lowest index on ties) until the consumer accepts.
//
// Ports:
//   clk_i      - clock
//   reset_n_i  - synchronous active-low reset
//   v_i        - per-requester valid [els_p]
//   tag_i      - packed tags, requester k at [k*width_p +: width_p]
//   yumi_o     - one-hot acknowledge to the granted requester (combinational)
//   v_o        - winner valid
//   id_o       - winner index
//   tag_o      - winner tag
//   yumi_i     - consumer accepts the winner
//
// Build option: define BSG_MIN_TAG_SCHED_SIGNED_EN for two's-complement tag
// comparison; otherwise tags compare unsigned. Ports and timing are identical.

module bsg_min_tag_sched #(
    parameter int els_p   = 4,
    parameter int width_p = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [els_p-1:0]           v_i,
    input  logic [els_p*width_p-1:0]   tag_i,
    output logic [els_p-1:0]           yumi_o,
    output logic                       v_o,
    output logic [$clog2(els_p)-1:0]   id_o,
    output logic [width_p-1:0]         tag_o,
    input  logic                       yumi_i
);

    localparam int unsigned id_w_lp  = $clog2(els_p);
    localparam int unsigned tags_w_lp = els_p * width_p;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        GRANT = 2'd2
    } state_e;

    state_e                 state_q,    state_d;
    logic [els_p-1:0]       mask_q,     mask_d;
    logic [tags_w_lp-1:0]   tag_q,      tag_d;
    logic [id_w_lp-1:0]     idx_q,      idx_d;
    logic                   best_v_q,   best_v_d;
    logic [id_w_lp-1:0]     best_id_q,  best_id_d;
    logic [width_p-1:0]     best_tag_q, best_tag_d;
    logic                   v_q,        v_d;

    logic [width_p-1:0]     cand_tag;
    logic                   cand_v;
    logic                   cand_lt;
    logic                   scan_last;

    // Candidate selection: mux the snapshot entry addressed by idx_q.
    always_comb begin
        cand_tag = '0;
        for (int k = 0; k < els_p; k++) begin
            if (idx_q == id_w_lp'(k)) begin
                cand_tag = tag_q[k*width_p +: width_p];
            end
        end
        cand_v    = mask_q[idx_q];
        scan_last = (idx_q == id_w_lp'(els_p - 1));
    end

    // The single shared comparator.
`ifdef BSG_MIN_TAG_SCHED_SIGNED_EN
    always_comb cand_lt = ($signed(cand_tag) < $signed(best_tag_q));
`else
    always_comb cand_lt = (cand_tag < best_tag_q);
`endif

    // Next-state and datapath updates.
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        tag_d      = tag_q;
        idx_d      = idx_q;
        best_v_d   = best_v_q;
        best_id_d  = best_id_q;
        best_tag_d = best_tag_q;

        unique case (state_q)
            IDLE: begin
                if (|v_i) begin
                    mask_d     = v_i;
                    tag_d      = tag_i;
                    idx_d      = '0;
                    best_v_d   = 1'b0;
                    best_id_d  = '0;
                    best_tag_d = '0;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                // Strict less-than: equal tags keep the earlier (lower) index.
                if (cand_v && (!best_v_q || cand_lt)) begin
                    best_v_d   = 1'b1;
                    best_id_d  = idx_q;
                    best_tag_d = cand_tag;
                end
                if (scan_last) begin
                    idx_d   = '0;
                    state_d = GRANT;
                end else begin
                    idx_d = idx_q + id_w_lp'(1);
                end
            end
            GRANT: begin
                if (yumi_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        v_d = (state_d == GRANT);
    end

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            tag_q      <= '0;
            idx_q      <= '0;
            best_v_q   <= 1'b0;
            best_id_q  <= '0;
            best_tag_q <= '0;
            v_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            tag_q      <= tag_d;
            idx_q      <= idx_d;
            best_v_q   <= best_v_d;
            best_id_q  <= best_id_d;
            best_tag_q <= best_tag_d;
            v_q        <= v_d;
        end
    end

    assign v_o   = v_q;
    assign id_o  = best_id_q;
    assign tag_o = best_tag_q;

    // Acknowledge is gated by reset so an abort in GRANT never pulses yumi_o.
    always_comb begin
        yumi_o = '0;
        if (v_q && yumi_i && reset_n_i) begin
            yumi_o[best_id_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_bsg_min_tag_sched.sv
// Directed bench for bsg_min_tag_sched at els_p=4, width_p=16.

module tb_bsg_min_tag_sched;

    logic        clk;
    logic        reset_n;
    logic [3:0]  v_i;
    logic [63:0] tag_i;
    logic [3:0]  yumi_o;
    logic        v_o;
    logic [1:0]  id_o;
    logic [15:0] tag_o;
    logic        yumi_i;

    int checks = 0;
    int errors = 0;

    bsg_min_tag_sched #(.els_p(4), .width_p(16)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .v_i       (v_i),
        .tag_i     (tag_i),
        .yumi_o    (yumi_o),
        .v_o       (v_o),
        .id_o      (id_o),
        .tag_o     (tag_o),
        .yumi_i    (yumi_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    // Waits (bounded) for v_o; returns number of cycles waited.
    task automatic wait_grant(output int n);
        n = 0;
        while (!v_o && n < 20) begin
            cyc();
            n++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        v_i     = 4'hF;
        tag_i   = 64'h1111_2222_3333_4444;
        yumi_i  = 1'b1;
        cyc();
        cyc();
        #1;
        checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL reset_v_o got=%0b exp=0", v_o); end
        checks++; if (id_o !== 2'd0) begin errors++; $display("FAIL reset_id_o got=%0d exp=0", id_o); end
        checks++; if (tag_o !== 16'h0) begin errors++; $display("FAIL reset_tag_o got=%h exp=0000", tag_o); end
        checks++; if (yumi_o !== 4'b0) begin errors++; $display("FAIL reset_yumi_o got=%b exp=0000", yumi_o); end
        v_i     = 4'h0;
        yumi_i  = 1'b0;
        reset_n = 1'b1;
        cyc();
        cyc();
    endtask

    task automatic test_basic();
        int n;
        v_i    = 4'b1111;
        tag_i  = {16'h0020, 16'h0030, 16'h0010, 16'h0040};
        yumi_i = 1'b0;
        wait_grant(n);
        checks++; if (n !== 5) begin errors++; $display("FAIL basic_latency got=%0d exp=5", n); end
        checks++; if (id_o !== 2'd1) begin errors++; $display("FAIL basic_id got=%0d exp=1", id_o); end
        checks++; if (tag_o !== 16'h0010) begin errors++; $display("FAIL basic_tag got=%h exp=0010", tag_o); end
        yumi_i = 1'b1;
        v_i    = 4'b0000;
        #1;
        checks++; if (yumi_o !== 4'b0010) begin errors++; $display("FAIL basic_yumi got=%b exp=0010", yumi_o); end
        cyc();
        yumi_i = 1'b0;
        checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL basic_release got=%0b exp=0", v_o); end
        cyc();
    endtask

    task automatic test_tie();
        int n;
        v_i    = 4'b1010;
        tag_i  = {16'h0005, 16'h0002, 16'h0005, 16'h0001};
        yumi_i = 1'b0;
        wait_grant(n);
        checks++; if (n !== 5) begin errors++; $display("FAIL tie_latency got=%0d exp=5", n); end
        checks++; if (id_o !== 2'd1) begin errors++; $display("FAIL tie_id got=%0d exp=1", id_o); end
        checks++; if (tag_o !== 16'h0005) begin errors++; $display("FAIL tie_tag got=%h exp=0005", tag_o); end
        yumi_i = 1'b1;
        v_i    = 4'b0000;
        #1;
        checks++; if (yumi_o !== 4'b0010) begin errors++; $display("FAIL tie_yumi got=%b exp=0010", yumi_o); end
        cyc();
        yumi_i = 1'b0;
        cyc();
    endtask

    task automatic test_signed();
        int n;
        logic [1:0]  exp_id;
        logic [15:0] exp_tag;
`ifdef BSG_MIN_TAG_SCHED_SIGNED_EN
        exp_id  = 2'd0;
        exp_tag = 16'h8000;
`else
        exp_id  = 2'd1;
        exp_tag = 16'h7FFF;
`endif
        v_i    = 4'b0011;
        tag_i  = {16'h0000, 16'h0000, 16'h7FFF, 16'h8000};
        yumi_i = 1'b0;
        wait_grant(n);
        checks++; if (n !== 5) begin errors++; $display("FAIL sign_latency got=%0d exp=5", n); end
        checks++; if (id_o !== exp_id) begin errors++; $display("FAIL sign_id got=%0d exp=%0d", id_o, exp_id); end
        checks++; if (tag_o !== exp_tag) begin errors++; $display("FAIL sign_tag got=%h exp=%h", tag_o, exp_tag); end
        yumi_i = 1'b1;
        v_i    = 4'b0000;
        cyc();
        yumi_i = 1'b0;
        cyc();
    endtask

    task automatic test_hold();
        int n;
        v_i    = 4'b1111;
        tag_i  = {16'h0020, 16'h0030, 16'h0010, 16'h0040};
        yumi_i = 1'b0;
        wait_grant(n);
        checks++; if (n !== 5) begin errors++; $display("FAIL hold_latency got=%0d exp=5", n); end
        for (int i = 0; i < 10; i++) begin
            v_i   = 4'($urandom);
            tag_i = {$urandom, $urandom};
            cyc();
            #1;
            checks++; if (v_o !== 1'b1) begin errors++; $display("FAIL hold_v_o cyc=%0d got=%0b exp=1", i, v_o); end
            checks++; if (id_o !== 2'd1) begin errors++; $display("FAIL hold_id cyc=%0d got=%0d exp=1", i, id_o); end
            checks++; if (tag_o !== 16'h0010) begin errors++; $display("FAIL hold_tag cyc=%0d got=%h exp=0010", i, tag_o); end
            checks++; if (yumi_o !== 4'b0) begin errors++; $display("FAIL hold_yumi cyc=%0d got=%b exp=0000", i, yumi_o); end
        end
        yumi_i = 1'b1;
        v_i    = 4'b0000;
        cyc();
        yumi_i = 1'b0;
        checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL hold_release got=%0b exp=0", v_o); end
        cyc();
    endtask

    task automatic test_idle_yumi();
        v_i    = 4'b0000;
        yumi_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL idle_v_o cyc=%0d got=%0b exp=0", i, v_o); end
            checks++; if (yumi_o !== 4'b0) begin errors++; $display("FAIL idle_yumi cyc=%0d got=%b exp=0000", i, yumi_o); end
        end
        yumi_i = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid_scan();
        v_i    = 4'b1111;
        tag_i  = {16'h0020, 16'h0030, 16'h0010, 16'h0040};
        yumi_i = 1'b1;
        cyc();
        cyc();
        cyc();
        // scan index 2 in this cycle
        reset_n = 1'b0;
        #1;
        checks++; if (yumi_o !== 4'b0) begin errors++; $display("FAIL rscan_yumi_in_reset got=%b exp=0000", yumi_o); end
        cyc();
        reset_n = 1'b1;
        checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL rscan_v_o_after got=%0b exp=0", v_o); end
        for (int i = 0; i < 4; i++) begin
            cyc();
            #1;
            checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL rscan_early_v cyc=%0d got=%0b exp=0", i, v_o); end
            checks++; if (yumi_o !== 4'b0) begin errors++; $display("FAIL rscan_early_yumi cyc=%0d got=%b exp=0000", i, yumi_o); end
        end
        cyc();
        #1;
        checks++; if (v_o !== 1'b1) begin errors++; $display("FAIL rscan_grant_v got=%0b exp=1", v_o); end
        checks++; if (id_o !== 2'd1) begin errors++; $display("FAIL rscan_grant_id got=%0d exp=1", id_o); end
        checks++; if (yumi_o !== 4'b0010) begin errors++; $display("FAIL rscan_grant_yumi got=%b exp=0010", yumi_o); end
        v_i = 4'b0000;
        cyc();
        yumi_i = 1'b0;
        cyc();
    endtask

    task automatic test_reset_in_grant();
        int n;
        v_i    = 4'b0101;
        tag_i  = {16'h0000, 16'h0003, 16'h0000, 16'h0009};
        yumi_i = 1'b0;
        wait_grant(n);
        checks++; if (id_o !== 2'd2) begin errors++; $display("FAIL rgrant_id got=%0d exp=2", id_o); end
        reset_n = 1'b0;
        yumi_i  = 1'b1;
        #1;
        checks++; if (yumi_o !== 4'b0) begin errors++; $display("FAIL rgrant_yumi got=%b exp=0000", yumi_o); end
        cyc();
        reset_n = 1'b1;
        yumi_i  = 1'b0;
        v_i     = 4'b0000;
        checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL rgrant_v_o got=%0b exp=0", v_o); end
        checks++; if (tag_o !== 16'h0) begin errors++; $display("FAIL rgrant_tag got=%h exp=0000", tag_o); end
        cyc();
    endtask

    task automatic test_back_to_back();
        int ids [4];
        int tags[4];
        int when[4];
        int ng;
        int exp_ids [4] = '{1, 3, 2, 0};
        int exp_tags[4] = '{16, 32, 48, 64};
        ng     = 0;
        v_i    = 4'b1111;
        tag_i  = {16'h0020, 16'h0030, 16'h0010, 16'h0040};
        yumi_i = 1'b1;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            #1;
            if (yumi_o != 4'b0) begin
                for (int k = 0; k < 4; k++) begin
                    if (yumi_o[k]) begin
                        ids[ng]  = k;
                        v_i[k]   = 1'b0;
                    end
                end
                tags[ng] = int'(tag_o);
                when[ng] = c;
                ng++;
            end
            cyc();
        end
        yumi_i = 1'b0;
        checks++; if (ng !== 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", ng); end
        for (int i = 0; i < ng; i++) begin
            checks++; if (ids[i] !== exp_ids[i]) begin errors++; $display("FAIL b2b_id[%0d] got=%0d exp=%0d", i, ids[i], exp_ids[i]); end
            checks++; if (tags[i] !== exp_tags[i]) begin errors++; $display("FAIL b2b_tag[%0d] got=%0d exp=%0d", i, tags[i], exp_tags[i]); end
            if (i > 0) begin
                checks++; if (when[i] - when[i-1] < 6) begin errors++; $display("FAIL b2b_spacing[%0d] got=%0d exp>=6", i, when[i] - when[i-1]); end
            end
        end
        if (ng > 0) begin
            checks++; if (when[0] !== 5) begin errors++; $display("FAIL b2b_first got=%0d exp=5", when[0]); end
        end
        cyc();
    endtask

    initial begin
        reset_n = 1'b0;
        v_i     = 4'b0;
        tag_i   = 64'b0;
        yumi_i  = 1'b0;
        cyc();
        test_reset();
        test_basic();
        test_tie();
        test_signed();
        test_hold();
        test_idle_yumi();
        test_reset_mid_scan();
        test_reset_in_grant();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
